// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, float field widths and the
// per-stage payload carried down the float-to-int pipeline.
package fpu_pkg;

    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned MAG_W    = 32;

    typedef enum logic [1:0] {
        RM_RNA = 2'b00,
        RM_RNE = 2'b01,
        RM_RTZ = 2'b10,
        RM_RDN = 2'b11
    } rm_e;

    typedef enum logic [2:0] {
        SpNone,
        SpZero,
        SpNan,
        SpInf,
        SpOvf
    } spc_e;

    // Decoded operand after alignment: integer magnitude plus round bits.
    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
        logic             guard;
        logic             sticky;
        rm_e              rm;
        spc_e             spc;
    } stage_t;

    // Rounded, range-checked result waiting for negate/saturate.
    typedef struct packed {
        logic             neg;
        logic             sat;
        logic             nx;
        logic [MAG_W-1:0] mag;
    } res_t;

endpackage

// File: rtl/fp_round_inc.sv
// Round-increment decision shared by the FPU conversion units: given the
// truncated magnitude's lsb and the dropped guard/sticky bits, add one ulp?
module fp_round_inc
    import fpu_pkg::*;
(
    input  rm_e  rm_i,
    input  logic sign_i,
    input  logic lsb_i,
    input  logic guard_i,
    input  logic sticky_i,
    output logic inc_o
);

    always_comb begin
        inc_o = 1'b0;
        unique case (rm_i)
            RM_RNA:  inc_o = guard_i;
            RM_RNE:  inc_o = guard_i & (sticky_i | lsb_i);
            RM_RTZ:  inc_o = 1'b0;
            RM_RDN:  inc_o = sign_i & (guard_i | sticky_i);
            default: inc_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ftoi_pipe.sv
// Three-stage single-precision float to signed INT_W-bit integer converter
// with per-op rounding mode, saturation and invalid/inexact flags.
module ftoi_pipe
    import fpu_pkg::*;
#(
    parameter int unsigned INT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [31:0]      x1,
    input  logic [1:0]       rm,
    output logic [INT_W-1:0] y,
    output logic             valid,
    output logic             flag_nv,
    output logic             flag_nx,
    output logic             idle
);

    localparam logic [EXP_W-1:0] Bias  = EXP_W'(EXP_BIAS);
    localparam logic [EXP_W-1:0] ManW  = EXP_W'(MAN_W);
    localparam logic [EXP_W-1:0] ShOne = EXP_W'(1);
    localparam logic [EXP_W-1:0] MaxE  = EXP_W'(INT_W - 1);
    localparam logic [MAG_W-1:0] Lsb   = {{(MAG_W-1){1'b0}}, 1'b1};
    localparam logic [MAG_W:0]   One   = {{MAG_W{1'b0}}, 1'b1};
    localparam logic [MAG_W:0]   LimNeg = One << (INT_W - 1);
    localparam logic [MAG_W:0]   LimPos = LimNeg - One;
    localparam logic [INT_W-1:0] YMax  = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] YMin  = {1'b1, {(INT_W-1){1'b0}}};

    logic             s1_v_q, s2_v_q, valid_q;
    stage_t           s1_d, s1_q;
    res_t             s2_d, s2_q;
    logic [INT_W-1:0] y_d, y_q;
    logic             nv_d, nv_q, nx_d, nx_q;

    logic [EXP_W-1:0] exp_w, e_pos, sh;
    logic [MAN_W-1:0] man;
    logic [MAG_W-1:0] sig, frac;

    // S1: classify the operand and align {1,m} to the integer binary point.
    always_comb begin
        exp_w       = x1[30:23];
        man         = x1[22:0];
        sig         = {{(MAG_W-MAN_W-1){1'b0}}, 1'b1, man};
        e_pos       = exp_w - Bias;
        sh          = '0;
        frac        = '0;
        s1_d        = '0;
        s1_d.sign   = x1[31];
        s1_d.rm     = rm_e'(rm);
        s1_d.spc    = SpNone;
        if (exp_w == '0) begin
            s1_d.spc = SpZero;
        end else if (exp_w == '1) begin
            s1_d.spc = (man != '0) ? SpNan : SpInf;
        end else if (exp_w < Bias) begin
            // Below one: only the exponent -1 case has the leading 1 as guard.
            s1_d.guard  = (exp_w == Bias - ShOne);
            s1_d.sticky = !s1_d.guard || (man != '0);
        end else if (e_pos > MaxE) begin
            s1_d.spc = SpOvf;
        end else if (e_pos >= ManW) begin
            s1_d.mag = sig << (e_pos - ManW);
        end else begin
            sh          = ManW - e_pos;
            s1_d.mag    = sig >> sh;
            frac        = sig & ((Lsb << sh) - Lsb);
            s1_d.guard  = |(frac >> (sh - ShOne));
            s1_d.sticky = |(frac & ((Lsb << (sh - ShOne)) - Lsb));
        end
    end

    // S2: apply the round increment and check the signed range.
    logic           inc;
    logic [MAG_W:0] sum;

    fp_round_inc u_round_inc (
        .rm_i     (s1_q.rm),
        .sign_i   (s1_q.sign),
        .lsb_i    (s1_q.mag[0]),
        .guard_i  (s1_q.guard),
        .sticky_i (s1_q.sticky),
        .inc_o    (inc)
    );

    always_comb begin
        sum      = {1'b0, s1_q.mag} + {{MAG_W{1'b0}}, inc};
        s2_d.neg = s1_q.sign;
        s2_d.sat = 1'b0;
        s2_d.nx  = s1_q.guard | s1_q.sticky;
        s2_d.mag = sum[MAG_W-1:0];
        unique case (s1_q.spc)
            SpZero: begin
                s2_d.neg = 1'b0;
                s2_d.nx  = 1'b0;
                s2_d.mag = '0;
            end
            SpNan: begin
                s2_d.neg = 1'b0;
                s2_d.sat = 1'b1;
            end
            SpInf, SpOvf: s2_d.sat = 1'b1;
            default:      s2_d.sat = s1_q.sign ? (sum > LimNeg) : (sum > LimPos);
        endcase
    end

    // S3: saturate or negate into the output register.
    always_comb begin
        if (s2_q.sat) begin
            y_d  = s2_q.neg ? YMin : YMax;
            nv_d = 1'b1;
            nx_d = 1'b0;
        end else begin
            y_d  = s2_q.neg ? INT_W'(-s2_q.mag) : INT_W'(s2_q.mag);
            nv_d = 1'b0;
            nx_d = s2_q.nx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
            valid_q <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            y_q     <= '0;
            nv_q    <= 1'b0;
            nx_q    <= 1'b0;
        end else begin
            s1_v_q  <= en;
            s2_v_q  <= s1_v_q;
            valid_q <= s2_v_q;
            if (en) begin
                s1_q <= s1_d;
            end
            if (s1_v_q) begin
                s2_q <= s2_d;
            end
            if (s2_v_q) begin
                y_q  <= y_d;
                nv_q <= nv_d;
                nx_q <= nx_d;
            end
        end
    end

    assign y       = y_q;
    assign valid   = valid_q;
    assign flag_nv = nv_q;
    assign flag_nx = nx_q;
    assign idle    = ~(s1_v_q | s2_v_q);

endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe: 32- and 16-bit instances fed the same ops, checked
// every cycle against an exact arithmetic model of float-to-int rounding.
module tb_ftoi_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [31:0] x1;
    logic [1:0]  rm;

    logic [31:0] y32;
    logic        v32, nv32, nx32, idle32;
    logic [15:0] y16;
    logic        v16, nv16, nx16, idle16;

    always #5 clk = ~clk;

    ftoi_pipe #(.INT_W(32)) dut32 (
        .clk(clk), .rstn(rstn), .en(en), .x1(x1), .rm(rm),
        .y(y32), .valid(v32), .flag_nv(nv32), .flag_nx(nx32), .idle(idle32)
    );

    ftoi_pipe #(.INT_W(16)) dut16 (
        .clk(clk), .rstn(rstn), .en(en), .x1(x1), .rm(rm),
        .y(y16), .valid(v16), .flag_nv(nv16), .flag_nx(nx16), .idle(idle16)
    );

    typedef struct {
        int          due;
        logic [31:0] y32;
        logic        nv32, nx32;
        logic [15:0] y16;
        logic        nv16, nx16;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_y32;
    logic [15:0] last_y16;
    logic        last_nv32, last_nx32, last_nv16, last_nx16;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Exact value as 32.32 fixed point, then round by the mode's definition.
    function automatic void model(input logic [31:0] x, input logic [1:0] r, input int w,
                                  output logic [31:0] yo, output logic nv, output logic nx);
        logic        s;
        int          e;
        logic [63:0] sig, fx, ip, fr;
        longint      mag, res, maxv, minv;
        s    = x[31];
        e    = int'(x[30:23]) - 127;
        sig  = {40'd0, 1'b1, x[22:0]};
        maxv = (longint'(1) << (w - 1)) - 1;
        minv = -(longint'(1) << (w - 1));
        nv   = 1'b0;
        nx   = 1'b0;
        yo   = 32'd0;
        if (x[30:23] == 8'd0) return;
        if (x[30:23] == 8'hFF) begin
            nv = 1'b1;
            yo = (x[22:0] == 23'd0 && s) ? 32'(minv) : 32'(maxv);
            return;
        end
        if (e >= w) begin
            nv = 1'b1;
            yo = s ? 32'(minv) : 32'(maxv);
            return;
        end
        if (e < -32) begin
            fx = 64'd1;
        end else if (e + 9 >= 0) begin
            fx = sig << (e + 9);
        end else begin
            fx = sig >> (-(e + 9));
            if ((sig & ((64'd1 << (-(e + 9))) - 64'd1)) != 64'd0) fx[0] = 1'b1;
        end
        ip  = fx >> 32;
        fr  = {32'd0, fx[31:0]};
        mag = longint'(ip);
        case (r)
            2'd0: if (fr >= 64'h8000_0000) mag++;
            2'd1: if (fr > 64'h8000_0000 || (fr == 64'h8000_0000 && ip[0])) mag++;
            2'd3: if (s && fr != 64'd0) mag++;
            default: ;
        endcase
        res = s ? -mag : mag;
        if (res > maxv) begin
            nv = 1'b1;
            yo = 32'(maxv);
        end else if (res < minv) begin
            nv = 1'b1;
            yo = 32'(minv);
        end else begin
            yo = 32'(res);
            nx = (fr != 64'd0);
        end
    endfunction

    task automatic pin(input logic [31:0] x, input logic [1:0] r, input int w,
                       input logic [31:0] yw, input logic nvw, input logic nxw);
        logic [31:0] yo;
        logic        nv, nx;
        model(x, r, w, yo, nv, nx);
        if (w == 16) yo = yo & 32'h0000_FFFF;
        chk($sformatf("model_y_%h_rm%0d_w%0d", x, r, w), yo, yw);
        chk($sformatf("model_flags_%h_rm%0d_w%0d", x, r, w), {30'd0, nv, nx}, {30'd0, nvw, nxw});
    endtask

    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        if (rstn === 1'b1 && en === 1'b1) begin
            logic [31:0] t;
            e.due = cyc + 2;
            model(x1, rm, 32, e.y32, e.nv32, e.nx32);
            model(x1, rm, 16, t, e.nv16, e.nx16);
            e.y16 = t[15:0];
            q.push_back(e);
        end
    end

    initial begin
        last_y32  = '0;
        last_y16  = '0;
        last_nv32 = 1'b0;
        last_nx32 = 1'b0;
        last_nv16 = 1'b0;
        last_nx16 = 1'b0;
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                last_y32  = e.y32;
                last_nv32 = e.nv32;
                last_nx32 = e.nx32;
                last_y16  = e.y16;
                last_nv16 = e.nv16;
                last_nx16 = e.nx16;
                chk("valid32", {31'd0, v32}, 32'd1);
                chk("valid16", {31'd0, v16}, 32'd1);
            end else begin
                chk("valid32_idle", {31'd0, v32}, 32'd0);
                chk("valid16_idle", {31'd0, v16}, 32'd0);
            end
            chk("y32", y32, last_y32);
            chk("flags32", {30'd0, nv32, nx32}, {30'd0, last_nv32, last_nx32});
            chk("y16", {16'd0, y16}, {16'd0, last_y16});
            chk("flags16", {30'd0, nv16, nx16}, {30'd0, last_nv16, last_nx16});
            chk("idle32", {31'd0, idle32}, {31'd0, q.size() == 0});
            chk("idle16", {31'd0, idle16}, {31'd0, q.size() == 0});
        end
    end

    task automatic issue(input logic [31:0] x, input logic [1:0] r);
        @(negedge clk);
        en = 1'b1;
        x1 = x;
        rm = r;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            en = 1'b0;
        end
    endtask

    logic [33:0] dir [0:21] = '{
        {2'd0, 32'h3FC00000}, {2'd1, 32'h3FC00000}, {2'd2, 32'h3FC00000},
        {2'd3, 32'h3FC00000}, {2'd1, 32'h40200000}, {2'd0, 32'hC0200000},
        {2'd2, 32'hC0200000}, {2'd3, 32'hC0200000}, {2'd0, 32'h4F32D05E},
        {2'd0, 32'hCF000000}, {2'd0, 32'h7FC00000}, {2'd0, 32'h46FFFF00},
        {2'd2, 32'h46FFFF00}, {2'd3, 32'hBF000000}, {2'd0, 32'h7F800000},
        {2'd0, 32'hFF800000}, {2'd3, 32'h00000001}, {2'd3, 32'hB0000000},
        {2'd2, 32'h4F000000}, {2'd2, 32'hCF000001}, {2'd1, 32'h3F000000},
        {2'd1, 32'h3F400000}
    };

    logic [33:0] b2b [0:7] = '{
        {2'd1, 32'h3FC00000}, {2'd0, 32'hC0200000}, {2'd2, 32'h47000000},
        {2'd0, 32'h3EFFFFFF}, {2'd3, 32'hBFC00000}, {2'd1, 32'h4B7FFFFF},
        {2'd0, 32'h80000000}, {2'd1, 32'h40600000}
    };

    initial begin
        rstn = 1'b0;
        en   = 1'b0;
        x1   = '0;
        rm   = '0;

        pin(32'h3FC00000, 2'd0, 32, 32'd2, 1'b0, 1'b1);
        pin(32'h3FC00000, 2'd1, 32, 32'd2, 1'b0, 1'b1);
        pin(32'h3FC00000, 2'd2, 32, 32'd1, 1'b0, 1'b1);
        pin(32'h3FC00000, 2'd3, 32, 32'd1, 1'b0, 1'b1);
        pin(32'h40200000, 2'd1, 32, 32'd2, 1'b0, 1'b1);
        pin(32'hC0200000, 2'd0, 32, 32'hFFFFFFFD, 1'b0, 1'b1);
        pin(32'hC0200000, 2'd2, 32, 32'hFFFFFFFE, 1'b0, 1'b1);
        pin(32'hC0200000, 2'd3, 32, 32'hFFFFFFFD, 1'b0, 1'b1);
        pin(32'h4F32D05E, 2'd0, 32, 32'h7FFFFFFF, 1'b1, 1'b0);
        pin(32'hCF000000, 2'd0, 32, 32'h80000000, 1'b0, 1'b0);
        pin(32'h7FC00000, 2'd0, 32, 32'h7FFFFFFF, 1'b1, 1'b0);
        pin(32'h46FFFF00, 2'd0, 16, 32'h00007FFF, 1'b1, 1'b0);
        pin(32'h46FFFF00, 2'd2, 16, 32'h00007FFF, 1'b0, 1'b1);
        pin(32'hBF000000, 2'd3, 16, 32'h0000FFFF, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;

        for (int i = 0; i < 22; i++) begin
            issue(dir[i][31:0], dir[i][33:32]);
            gap(4);
        end

        for (int i = 0; i < 8; i++) begin
            issue(b2b[i][31:0], b2b[i][33:32]);
        end
        gap(6);
        chk("drained_idle32", {31'd0, idle32}, 32'd1);
        chk("drained_idle16", {31'd0, idle16}, 32'd1);
        chk("drained_queue", q.size(), 32'd0);

        // Two ops in flight when reset hits: neither may ever emerge.
        issue(32'h40600000, 2'd0);
        issue(32'hC0200000, 2'd0);
        @(negedge clk);
        en = 1'b0;
        #2 rstn = 1'b0;
        q.delete();
        last_y32  = '0;
        last_y16  = '0;
        last_nv32 = 1'b0;
        last_nx32 = 1'b0;
        last_nv16 = 1'b0;
        last_nx16 = 1'b0;
        #1;
        chk("rst_y32", y32, 32'd0);
        chk("rst_valid32", {31'd0, v32}, 32'd0);
        chk("rst_flags32", {30'd0, nv32, nx32}, 32'd0);
        chk("rst_idle32", {31'd0, idle32}, 32'd1);
        chk("rst_y16", {16'd0, y16}, 32'd0);
        chk("rst_idle16", {31'd0, idle16}, 32'd1);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        gap(4);
        issue(32'h3FC00000, 2'd0);
        gap(5);
        chk("post_reset_y32", y32, 32'd2);
        chk("post_reset_nx32", {31'd0, nx32}, 32'd1);
        chk("final_queue", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
